// File: rtl/config_chain_loader.sv
// Writer side of the tile configuration chain: accepts bitstream words and
// shifts them LSB-first into the daisy-chained config registers.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 36
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      remaining_reg, remaining_next;
  logic [WORD_WIDTH-1:0] shifter_reg, shifter_next;
  logic [IDX_W-1:0]      sh_idx_reg, sh_idx_next;
  logic                  sh_full_reg, sh_full_next;
  logic [WORD_WIDTH-1:0] hold_reg, hold_next;
  logic                  hold_full_reg, hold_full_next;
  logic                  cfg_out_reg, cfg_out_next;
  logic                  cfg_en_reg, cfg_en_next;
  logic                  done_reg, done_next;

  logic                  take;
  logic [WORD_WIDTH-1:0] src_word;
  logic [IDX_W-1:0]      src_idx;
  logic                  src_valid;

  assign data_ready    = (state_reg == ST_SHIFT) && !hold_full_reg;
  assign take          = data_valid && data_ready;
  assign busy          = (state_reg == ST_SHIFT);
  assign config_out    = cfg_out_reg;
  assign config_enable = cfg_en_reg;
  assign done          = done_reg;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      shifter_reg   <= '0;
      sh_idx_reg    <= '0;
      sh_full_reg   <= 1'b0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      cfg_out_reg   <= 1'b0;
      cfg_en_reg    <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      shifter_reg   <= shifter_next;
      sh_idx_reg    <= sh_idx_next;
      sh_full_reg   <= sh_full_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      cfg_out_reg   <= cfg_out_next;
      cfg_en_reg    <= cfg_en_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    shifter_next   = shifter_reg;
    sh_idx_next    = sh_idx_reg;
    sh_full_next   = sh_full_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    cfg_out_next   = 1'b0;
    cfg_en_next    = 1'b0;
    done_next      = 1'b0;
    src_word       = '0;
    src_idx        = '0;
    src_valid      = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next     = ST_SHIFT;
          remaining_next = CNT_W'(CHAIN_LENGTH);
          shifter_next   = '0;
          sh_idx_next    = '0;
          sh_full_next   = 1'b0;
          hold_next      = '0;
          hold_full_next = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (remaining_reg == '0) begin
          // Leftover bits of the last word and any buffered word are dropped.
          state_next     = ST_DONE;
          done_next      = 1'b1;
          sh_full_next   = 1'b0;
          hold_full_next = 1'b0;
        end else begin
          // Source priority: partly drained shifter, then hold buffer, then
          // the word arriving this cycle (bypass keeps first-bit latency at 1).
          if (sh_full_reg) begin
            src_word  = shifter_reg;
            src_idx   = sh_idx_reg;
            src_valid = 1'b1;
            if (take) begin
              hold_next      = data_in;
              hold_full_next = 1'b1;
            end
          end else if (hold_full_reg) begin
            src_word       = hold_reg;
            src_valid      = 1'b1;
            hold_full_next = 1'b0;
          end else if (take) begin
            src_word  = data_in;
            src_valid = 1'b1;
          end

          if (src_valid) begin
            cfg_out_next   = src_word[src_idx];
            cfg_en_next    = 1'b1;
            remaining_next = remaining_reg - CNT_W'(1);
            shifter_next   = src_word;
            if (src_idx == IDX_W'(WORD_WIDTH - 1)) begin
              sh_full_next = 1'b0;
              sh_idx_next  = '0;
            end else begin
              sh_full_next = 1'b1;
              sh_idx_next  = src_idx + IDX_W'(1);
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Randomised bench for config_chain_loader: two instances (36-bit and 16-bit
// chains) checked against a queue of expected chain bits built from accepted words.
module tb_config_chain_loader;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic [1:0] start_w, valid_w, ready_w, cout_w, cen_w, busy_w, done_w;
  logic [7:0] data_w [2];

  always #5 clock = ~clock;

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(36)) dut_a (
    .clock(clock), .nreset(nreset), .start(start_w[0]), .data_in(data_w[0]),
    .data_valid(valid_w[0]), .data_ready(ready_w[0]), .config_out(cout_w[0]),
    .config_enable(cen_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(16)) dut_b (
    .clock(clock), .nreset(nreset), .start(start_w[1]), .data_in(data_w[1]),
    .data_valid(valid_w[1]), .data_ready(ready_w[1]), .config_out(cout_w[1]),
    .config_enable(cen_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  int   chain_len [2];
  bit   exp_q [$];
  int   pushed, cyc, en_cnt, first_en, last_en, done_cnt, done_cyc;
  logic last_acc;
  logic [7:0] fixed_w [5];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: observe outputs at negedge, update the model, return at posedge+1.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (cen_w[1-sel]) check("idle_dut_enable", 1, 0);
    if (cen_w[sel]) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (exp_q.size() == 0) check("spurious_enable", 1, 0);
      else check("chain_bit", int'(cout_w[sel]), int'(exp_q.pop_front()));
    end
    if (done_w[sel]) begin
      done_cnt++;
      done_cyc = cyc;
    end
    last_acc = valid_w[sel] && ready_w[sel];
    if (last_acc) begin
      for (int i = 0; i < 8; i++) begin
        if (pushed < chain_len[sel]) begin
          exp_q.push_back(data_w[sel][i]);
          pushed++;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap, input bit st);
    int t;
    logic acc;
    data_w[sel]  = w;
    valid_w[sel] = 1'b1;
    start_w[sel] = st;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      tick();
      start_w[sel] = 1'b0;
      acc = last_acc;
      t++;
    end
    check("accept_timeout", int'(acc), 1);
    valid_w[sel] = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic begin_load();
    exp_q.delete();
    pushed = 0; en_cnt = 0; first_en = -1; last_en = -1; done_cnt = 0; done_cyc = -1;
    start_w[sel] = 1'b1;
    tick();
    start_w[sel] = 1'b0;
    check("busy_after_start", int'(busy_w[sel]), 1);
  endtask

  // mode 0: fixed words streaming, 1: random streaming, 2: random gapped
  task automatic run_load(input int mode, input bit start_mid);
    int nw, t, gap;
    logic [7:0] w;
    nw = (chain_len[sel] + 7) / 8;
    begin_load();
    for (int k = 0; k < nw; k++) begin
      w   = (mode == 0) ? fixed_w[k] : 8'($urandom);
      gap = (mode == 2 && k != nw - 1) ? int'($urandom_range(1, 3)) : 0;
      send_word(w, gap, start_mid && (k == 2));
    end
    t = 0;
    while (done_cnt == 0 && t < 100) begin
      tick();
      t++;
    end
    tick();
    check("done_pulse_count", done_cnt, 1);
    check("enable_count", en_cnt, chain_len[sel]);
    check("bits_left", exp_q.size(), 0);
    check("done_after_last", done_cyc, last_en + 1);
    check("done_low_after", int'(done_w[sel]), 0);
    check("busy_in_done", int'(busy_w[sel]), 0);
    if (mode != 2) begin
      check("no_bubbles", last_en - first_en + 1, chain_len[sel]);
      check("done_latency", done_cyc - first_en, chain_len[sel]);
    end
    $display("load dut=%0d mode=%0d len=%0d enables=%0d done_cyc=%0d errors=%0d",
             sel, mode, chain_len[sel], en_cnt, done_cyc - first_en, errors);
  endtask

  initial begin
    chain_len[0] = 36; chain_len[1] = 16;
    fixed_w[0] = 8'hA5; fixed_w[1] = 8'h3C; fixed_w[2] = 8'hFF;
    fixed_w[3] = 8'h00; fixed_w[4] = 8'h0F;
    start_w = '0; valid_w = '0; data_w[0] = '0; data_w[1] = '0;
    cyc = 0; en_cnt = 0; first_en = -1; last_en = -1; done_cnt = 0; pushed = 0;

    repeat (3) tick();
    check("rst_enable", int'(cen_w[0]), 0);
    check("rst_ready", int'(ready_w[0]), 0);
    check("rst_busy", int'(busy_w[0]), 0);
    check("rst_done", int'(done_w[0]), 0);
    nreset = 1'b1;
    tick();
    check("idle_ready", int'(ready_w[0]), 0);

    // Asynchronous reset in the middle of a load.
    sel = 0;
    begin_load();
    send_word(8'h5A, 0, 1'b0);
    send_word(8'hC3, 0, 1'b0);
    #1 nreset = 1'b0;
    #1;
    check("midrst_enable", int'(cen_w[0]), 0);
    check("midrst_out", int'(cout_w[0]), 0);
    check("midrst_busy", int'(busy_w[0]), 0);
    check("midrst_ready", int'(ready_w[0]), 0);
    check("midrst_done", int'(done_w[0]), 0);
    exp_q.delete();
    repeat (2) tick();
    nreset = 1'b1;
    tick();
    $display("reset mid-load checked errors=%0d", errors);

    run_load(0, 1'b1);

    // Word offered while in DONE must be refused and produce no shifts.
    data_w[0] = 8'($urandom);
    valid_w[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("done_ready", int'(ready_w[0]), 0);
      check("done_enable", int'(cen_w[0]), 0);
      tick();
    end
    valid_w[0] = 1'b0;
    check("extra_enables", en_cnt, 36);
    $display("extra word in DONE checked errors=%0d", errors);

    run_load(1, 1'b0);
    for (int r = 0; r < 3; r++) run_load(2, r[0]);

    sel = 1;
    run_load(1, 1'b0);
    run_load(2, 1'b0);
    run_load(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
